axi4_id_arbiter: RTL and testbench

AXI4_ID_ARBITER -- requirements
Module: axi4_id_arbiter

---
 rtl/axi4_id_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4_id_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_id_arbiter.sv
// Two-requester AXI4 arbiter onto one slave port; AW/AR round-robin with grant hold, write bursts locked to the AW winner.
// Zero-cycle: every channel is combinational from input to output; only grant pointers, hold registers and write state are registered.
// Backpressure: each ready follows the slave ready for the granted/routed requester only; all others see ready=0.
module axi4_id_arbiter (
  input  logic        clock,
  input  logic        reset,
  // requester 0
  input  logic        auto_in0_aw_valid,
  output logic        auto_in0_aw_ready,
  input  logic [2:0]  auto_in0_aw_bits_id,
  input  logic [30:0] auto_in0_aw_bits_addr,
  input  logic [7:0]  auto_in0_aw_bits_len,
  input  logic        auto_in0_w_valid,
  output logic        auto_in0_w_ready,
  input  logic [63:0] auto_in0_w_bits_data,
  input  logic [7:0]  auto_in0_w_bits_strb,
  input  logic        auto_in0_w_bits_last,
  input  logic        auto_in0_b_ready,
  output logic        auto_in0_b_valid,
  output logic [2:0]  auto_in0_b_bits_id,
  output logic [1:0]  auto_in0_b_bits_resp,
  input  logic        auto_in0_ar_valid,
  output logic        auto_in0_ar_ready,
  input  logic [2:0]  auto_in0_ar_bits_id,
  input  logic [30:0] auto_in0_ar_bits_addr,
  input  logic [7:0]  auto_in0_ar_bits_len,
  input  logic        auto_in0_r_ready,
  output logic        auto_in0_r_valid,
  output logic [2:0]  auto_in0_r_bits_id,
  output logic [63:0] auto_in0_r_bits_data,
  output logic [1:0]  auto_in0_r_bits_resp,
  output logic        auto_in0_r_bits_last,
  // requester 1
  input  logic        auto_in1_aw_valid,
  output logic        auto_in1_aw_ready,
  input  logic [2:0]  auto_in1_aw_bits_id,
  input  logic [30:0] auto_in1_aw_bits_addr,
  input  logic [7:0]  auto_in1_aw_bits_len,
  input  logic        auto_in1_w_valid,
  output logic        auto_in1_w_ready,
  input  logic [63:0] auto_in1_w_bits_data,
  input  logic [7:0]  auto_in1_w_bits_strb,
  input  logic        auto_in1_w_bits_last,
  input  logic        auto_in1_b_ready,
  output logic        auto_in1_b_valid,
  output logic [2:0]  auto_in1_b_bits_id,
  output logic [1:0]  auto_in1_b_bits_resp,
  input  logic        auto_in1_ar_valid,
  output logic        auto_in1_ar_ready,
  input  logic [2:0]  auto_in1_ar_bits_id,
  input  logic [30:0] auto_in1_ar_bits_addr,
  input  logic [7:0]  auto_in1_ar_bits_len,
  input  logic        auto_in1_r_ready,
  output logic        auto_in1_r_valid,
  output logic [2:0]  auto_in1_r_bits_id,
  output logic [63:0] auto_in1_r_bits_data,
  output logic [1:0]  auto_in1_r_bits_resp,
  output logic        auto_in1_r_bits_last,
  // shared slave
  output logic        auto_out_aw_valid,
  input  logic        auto_out_aw_ready,
  output logic [3:0]  auto_out_aw_bits_id,
  output logic [30:0] auto_out_aw_bits_addr,
  output logic [7:0]  auto_out_aw_bits_len,
  output logic        auto_out_w_valid,
  input  logic        auto_out_w_ready,
  output logic [63:0] auto_out_w_bits_data,
  output logic [7:0]  auto_out_w_bits_strb,
  output logic        auto_out_w_bits_last,
  output logic        auto_out_b_ready,
  input  logic        auto_out_b_valid,
  input  logic [3:0]  auto_out_b_bits_id,
  input  logic [1:0]  auto_out_b_bits_resp,
  output logic        auto_out_ar_valid,
  input  logic        auto_out_ar_ready,
  output logic [3:0]  auto_out_ar_bits_id,
  output logic [30:0] auto_out_ar_bits_addr,
  output logic [7:0]  auto_out_ar_bits_len,
  output logic        auto_out_r_ready,
  input  logic        auto_out_r_valid,
  input  logic [3:0]  auto_out_r_bits_id,
  input  logic [63:0] auto_out_r_bits_data,
  input  logic [1:0]  auto_out_r_bits_resp,
  input  logic        auto_out_r_bits_last
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST0 = 2'd1,
    BURST1 = 2'd2
  } wr_state_t;

  wr_state_t wr_state, wr_state_nxt;

  logic aw_ptr, aw_hold, aw_sel, aw_grant, aw_en, aw_fire;
  logic ar_ptr, ar_hold, ar_sel, ar_grant, ar_en, ar_fire;

  // Address acceptance is suppressed while reset is low so no handshake can slip out during reset.
  assign aw_en = reset && (wr_state == IDLE);
  assign ar_en = reset;

  // AW winner: held grant first, then pointer side on contention, else whichever requester is valid.
  always_comb begin
    aw_grant = 1'b0;
    if (aw_hold)
      aw_grant = aw_sel;
    else if (auto_in0_aw_valid && auto_in1_aw_valid)
      aw_grant = aw_ptr;
    else
      aw_grant = auto_in1_aw_valid;
  end

  assign auto_out_aw_valid     = aw_en && (aw_grant ? auto_in1_aw_valid : auto_in0_aw_valid);
  assign auto_out_aw_bits_id   = {aw_grant, aw_grant ? auto_in1_aw_bits_id : auto_in0_aw_bits_id};
  assign auto_out_aw_bits_addr = aw_grant ? auto_in1_aw_bits_addr : auto_in0_aw_bits_addr;
  assign auto_out_aw_bits_len  = aw_grant ? auto_in1_aw_bits_len : auto_in0_aw_bits_len;
  assign auto_in0_aw_ready     = aw_en && !aw_grant && auto_out_aw_ready;
  assign auto_in1_aw_ready     = aw_en &&  aw_grant && auto_out_aw_ready;
  assign aw_fire               = auto_out_aw_valid && auto_out_aw_ready;

  // AW pointer/hold: lock the winner while stalled, hand priority to the other side after a handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_ptr  <= 1'b0;
      aw_hold <= 1'b0;
      aw_sel  <= 1'b0;
    end else if (aw_fire) begin
      aw_ptr  <= ~aw_grant;
      aw_hold <= 1'b0;
    end else if (auto_out_aw_valid) begin
      aw_hold <= 1'b1;
      aw_sel  <= aw_grant;
    end
  end

  // AR winner: same policy as AW, without any burst lock.
  always_comb begin
    ar_grant = 1'b0;
    if (ar_hold)
      ar_grant = ar_sel;
    else if (auto_in0_ar_valid && auto_in1_ar_valid)
      ar_grant = ar_ptr;
    else
      ar_grant = auto_in1_ar_valid;
  end

  assign auto_out_ar_valid     = ar_en && (ar_grant ? auto_in1_ar_valid : auto_in0_ar_valid);
  assign auto_out_ar_bits_id   = {ar_grant, ar_grant ? auto_in1_ar_bits_id : auto_in0_ar_bits_id};
  assign auto_out_ar_bits_addr = ar_grant ? auto_in1_ar_bits_addr : auto_in0_ar_bits_addr;
  assign auto_out_ar_bits_len  = ar_grant ? auto_in1_ar_bits_len : auto_in0_ar_bits_len;
  assign auto_in0_ar_ready     = ar_en && !ar_grant && auto_out_ar_ready;
  assign auto_in1_ar_ready     = ar_en &&  ar_grant && auto_out_ar_ready;
  assign ar_fire               = auto_out_ar_valid && auto_out_ar_ready;

  // AR pointer/hold register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ar_ptr  <= 1'b0;
      ar_hold <= 1'b0;
      ar_sel  <= 1'b0;
    end else if (ar_fire) begin
      ar_ptr  <= ~ar_grant;
      ar_hold <= 1'b0;
    end else if (auto_out_ar_valid) begin
      ar_hold <= 1'b1;
      ar_sel  <= ar_grant;
    end
  end

  // Write state register; reset drops any burst in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      wr_state <= IDLE;
    else
      wr_state <= wr_state_nxt;
  end

  // Write next-state and W steering: only the AW winner's W reaches the slave until its last beat.
  always_comb begin
    wr_state_nxt         = wr_state;
    auto_out_w_valid     = 1'b0;
    auto_out_w_bits_data = '0;
    auto_out_w_bits_strb = '0;
    auto_out_w_bits_last = 1'b0;
    auto_in0_w_ready     = 1'b0;
    auto_in1_w_ready     = 1'b0;
    case (wr_state)
      IDLE: begin
        if (aw_fire)
          wr_state_nxt = aw_grant ? BURST1 : BURST0;
      end
      BURST0: begin
        auto_out_w_valid     = auto_in0_w_valid;
        auto_out_w_bits_data = auto_in0_w_bits_data;
        auto_out_w_bits_strb = auto_in0_w_bits_strb;
        auto_out_w_bits_last = auto_in0_w_bits_last;
        auto_in0_w_ready     = auto_out_w_ready;
        if (auto_in0_w_valid && auto_out_w_ready && auto_in0_w_bits_last)
          wr_state_nxt = IDLE;
      end
      BURST1: begin
        auto_out_w_valid     = auto_in1_w_valid;
        auto_out_w_bits_data = auto_in1_w_bits_data;
        auto_out_w_bits_strb = auto_in1_w_bits_strb;
        auto_out_w_bits_last = auto_in1_w_bits_last;
        auto_in1_w_ready     = auto_out_w_ready;
        if (auto_in1_w_valid && auto_out_w_ready && auto_in1_w_bits_last)
          wr_state_nxt = IDLE;
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  // Responses route on the top ID bit, which carries the original grant index.
  assign auto_in0_b_valid     = auto_out_b_valid && !auto_out_b_bits_id[3];
  assign auto_in1_b_valid     = auto_out_b_valid &&  auto_out_b_bits_id[3];
  assign auto_in0_b_bits_id   = auto_out_b_bits_id[2:0];
  assign auto_in1_b_bits_id   = auto_out_b_bits_id[2:0];
  assign auto_in0_b_bits_resp = auto_out_b_bits_resp;
  assign auto_in1_b_bits_resp = auto_out_b_bits_resp;
  assign auto_out_b_ready     = auto_out_b_bits_id[3] ? auto_in1_b_ready : auto_in0_b_ready;

  assign auto_in0_r_valid     = auto_out_r_valid && !auto_out_r_bits_id[3];
  assign auto_in1_r_valid     = auto_out_r_valid &&  auto_out_r_bits_id[3];
  assign auto_in0_r_bits_id   = auto_out_r_bits_id[2:0];
  assign auto_in1_r_bits_id   = auto_out_r_bits_id[2:0];
  assign auto_in0_r_bits_data = auto_out_r_bits_data;
  assign auto_in1_r_bits_data = auto_out_r_bits_data;
  assign auto_in0_r_bits_resp = auto_out_r_bits_resp;
  assign auto_in1_r_bits_resp = auto_out_r_bits_resp;
  assign auto_in0_r_bits_last = auto_out_r_bits_last;
  assign auto_in1_r_bits_last = auto_out_r_bits_last;
  assign auto_out_r_ready     = auto_out_r_bits_id[3] ? auto_in1_r_ready : auto_in0_r_ready;

endmodule

// File: tb/tb_axi4_id_arbiter.sv
// Directed bench for axi4_id_arbiter: reset gating, AW/AR round-robin and hold, write burst lock, response routing.
// Inputs are driven 1 time unit after the rising edge; outputs are compared 1 unit later, away from any edge.
// Stimulus never waits on the DUT, so the run always reaches its summary.
module tb_axi4_id_arbiter;

  logic        clock;
  logic        reset;
  logic        auto_in0_aw_valid, auto_in0_aw_ready;
  logic [2:0]  auto_in0_aw_bits_id;
  logic [30:0] auto_in0_aw_bits_addr;
  logic [7:0]  auto_in0_aw_bits_len;
  logic        auto_in0_w_valid, auto_in0_w_ready;
  logic [63:0] auto_in0_w_bits_data;
  logic [7:0]  auto_in0_w_bits_strb;
  logic        auto_in0_w_bits_last;
  logic        auto_in0_b_ready, auto_in0_b_valid;
  logic [2:0]  auto_in0_b_bits_id;
  logic [1:0]  auto_in0_b_bits_resp;
  logic        auto_in0_ar_valid, auto_in0_ar_ready;
  logic [2:0]  auto_in0_ar_bits_id;
  logic [30:0] auto_in0_ar_bits_addr;
  logic [7:0]  auto_in0_ar_bits_len;
  logic        auto_in0_r_ready, auto_in0_r_valid;
  logic [2:0]  auto_in0_r_bits_id;
  logic [63:0] auto_in0_r_bits_data;
  logic [1:0]  auto_in0_r_bits_resp;
  logic        auto_in0_r_bits_last;
  logic        auto_in1_aw_valid, auto_in1_aw_ready;
  logic [2:0]  auto_in1_aw_bits_id;
  logic [30:0] auto_in1_aw_bits_addr;
  logic [7:0]  auto_in1_aw_bits_len;
  logic        auto_in1_w_valid, auto_in1_w_ready;
  logic [63:0] auto_in1_w_bits_data;
  logic [7:0]  auto_in1_w_bits_strb;
  logic        auto_in1_w_bits_last;
  logic        auto_in1_b_ready, auto_in1_b_valid;
  logic [2:0]  auto_in1_b_bits_id;
  logic [1:0]  auto_in1_b_bits_resp;
  logic        auto_in1_ar_valid, auto_in1_ar_ready;
  logic [2:0]  auto_in1_ar_bits_id;
  logic [30:0] auto_in1_ar_bits_addr;
  logic [7:0]  auto_in1_ar_bits_len;
  logic        auto_in1_r_ready, auto_in1_r_valid;
  logic [2:0]  auto_in1_r_bits_id;
  logic [63:0] auto_in1_r_bits_data;
  logic [1:0]  auto_in1_r_bits_resp;
  logic        auto_in1_r_bits_last;
  logic        auto_out_aw_valid, auto_out_aw_ready;
  logic [3:0]  auto_out_aw_bits_id;
  logic [30:0] auto_out_aw_bits_addr;
  logic [7:0]  auto_out_aw_bits_len;
  logic        auto_out_w_valid, auto_out_w_ready;
  logic [63:0] auto_out_w_bits_data;
  logic [7:0]  auto_out_w_bits_strb;
  logic        auto_out_w_bits_last;
  logic        auto_out_b_ready, auto_out_b_valid;
  logic [3:0]  auto_out_b_bits_id;
  logic [1:0]  auto_out_b_bits_resp;
  logic        auto_out_ar_valid, auto_out_ar_ready;
  logic [3:0]  auto_out_ar_bits_id;
  logic [30:0] auto_out_ar_bits_addr;
  logic [7:0]  auto_out_ar_bits_len;
  logic        auto_out_r_ready, auto_out_r_valid;
  logic [3:0]  auto_out_r_bits_id;
  logic [63:0] auto_out_r_bits_data;
  logic [1:0]  auto_out_r_bits_resp;
  logic        auto_out_r_bits_last;

  int checks = 0;
  int errors = 0;

  axi4_id_arbiter dut (
    .clock(clock), .reset(reset),
    .auto_in0_aw_valid(auto_in0_aw_valid), .auto_in0_aw_ready(auto_in0_aw_ready),
    .auto_in0_aw_bits_id(auto_in0_aw_bits_id), .auto_in0_aw_bits_addr(auto_in0_aw_bits_addr),
    .auto_in0_aw_bits_len(auto_in0_aw_bits_len),
    .auto_in0_w_valid(auto_in0_w_valid), .auto_in0_w_ready(auto_in0_w_ready),
    .auto_in0_w_bits_data(auto_in0_w_bits_data), .auto_in0_w_bits_strb(auto_in0_w_bits_strb),
    .auto_in0_w_bits_last(auto_in0_w_bits_last),
    .auto_in0_b_ready(auto_in0_b_ready), .auto_in0_b_valid(auto_in0_b_valid),
    .auto_in0_b_bits_id(auto_in0_b_bits_id), .auto_in0_b_bits_resp(auto_in0_b_bits_resp),
    .auto_in0_ar_valid(auto_in0_ar_valid), .auto_in0_ar_ready(auto_in0_ar_ready),
    .auto_in0_ar_bits_id(auto_in0_ar_bits_id), .auto_in0_ar_bits_addr(auto_in0_ar_bits_addr),
    .auto_in0_ar_bits_len(auto_in0_ar_bits_len),
    .auto_in0_r_ready(auto_in0_r_ready), .auto_in0_r_valid(auto_in0_r_valid),
    .auto_in0_r_bits_id(auto_in0_r_bits_id), .auto_in0_r_bits_data(auto_in0_r_bits_data),
    .auto_in0_r_bits_resp(auto_in0_r_bits_resp), .auto_in0_r_bits_last(auto_in0_r_bits_last),
    .auto_in1_aw_valid(auto_in1_aw_valid), .auto_in1_aw_ready(auto_in1_aw_ready),
    .auto_in1_aw_bits_id(auto_in1_aw_bits_id), .auto_in1_aw_bits_addr(auto_in1_aw_bits_addr),
    .auto_in1_aw_bits_len(auto_in1_aw_bits_len),
    .auto_in1_w_valid(auto_in1_w_valid), .auto_in1_w_ready(auto_in1_w_ready),
    .auto_in1_w_bits_data(auto_in1_w_bits_data), .auto_in1_w_bits_strb(auto_in1_w_bits_strb),
    .auto_in1_w_bits_last(auto_in1_w_bits_last),
    .auto_in1_b_ready(auto_in1_b_ready), .auto_in1_b_valid(auto_in1_b_valid),
    .auto_in1_b_bits_id(auto_in1_b_bits_id), .auto_in1_b_bits_resp(auto_in1_b_bits_resp),
    .auto_in1_ar_valid(auto_in1_ar_valid), .auto_in1_ar_ready(auto_in1_ar_ready),
    .auto_in1_ar_bits_id(auto_in1_ar_bits_id), .auto_in1_ar_bits_addr(auto_in1_ar_bits_addr),
    .auto_in1_ar_bits_len(auto_in1_ar_bits_len),
    .auto_in1_r_ready(auto_in1_r_ready), .auto_in1_r_valid(auto_in1_r_valid),
    .auto_in1_r_bits_id(auto_in1_r_bits_id), .auto_in1_r_bits_data(auto_in1_r_bits_data),
    .auto_in1_r_bits_resp(auto_in1_r_bits_resp), .auto_in1_r_bits_last(auto_in1_r_bits_last),
    .auto_out_aw_valid(auto_out_aw_valid), .auto_out_aw_ready(auto_out_aw_ready),
    .auto_out_aw_bits_id(auto_out_aw_bits_id), .auto_out_aw_bits_addr(auto_out_aw_bits_addr),
    .auto_out_aw_bits_len(auto_out_aw_bits_len),
    .auto_out_w_valid(auto_out_w_valid), .auto_out_w_ready(auto_out_w_ready),
    .auto_out_w_bits_data(auto_out_w_bits_data), .auto_out_w_bits_strb(auto_out_w_bits_strb),
    .auto_out_w_bits_last(auto_out_w_bits_last),
    .auto_out_b_ready(auto_out_b_ready), .auto_out_b_valid(auto_out_b_valid),
    .auto_out_b_bits_id(auto_out_b_bits_id), .auto_out_b_bits_resp(auto_out_b_bits_resp),
    .auto_out_ar_valid(auto_out_ar_valid), .auto_out_ar_ready(auto_out_ar_ready),
    .auto_out_ar_bits_id(auto_out_ar_bits_id), .auto_out_ar_bits_addr(auto_out_ar_bits_addr),
    .auto_out_ar_bits_len(auto_out_ar_bits_len),
    .auto_out_r_ready(auto_out_r_ready), .auto_out_r_valid(auto_out_r_valid),
    .auto_out_r_bits_id(auto_out_r_bits_id), .auto_out_r_bits_data(auto_out_r_bits_data),
    .auto_out_r_bits_resp(auto_out_r_bits_resp), .auto_out_r_bits_last(auto_out_r_bits_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    auto_in0_aw_valid = 0; auto_in0_aw_bits_id = 0; auto_in0_aw_bits_addr = 0; auto_in0_aw_bits_len = 0;
    auto_in0_w_valid = 0; auto_in0_w_bits_data = 0; auto_in0_w_bits_strb = 0; auto_in0_w_bits_last = 0;
    auto_in0_b_ready = 0; auto_in0_ar_valid = 0; auto_in0_ar_bits_id = 0; auto_in0_ar_bits_addr = 0;
    auto_in0_ar_bits_len = 0; auto_in0_r_ready = 0;
    auto_in1_aw_valid = 0; auto_in1_aw_bits_id = 0; auto_in1_aw_bits_addr = 0; auto_in1_aw_bits_len = 0;
    auto_in1_w_valid = 0; auto_in1_w_bits_data = 0; auto_in1_w_bits_strb = 0; auto_in1_w_bits_last = 0;
    auto_in1_b_ready = 0; auto_in1_ar_valid = 0; auto_in1_ar_bits_id = 0; auto_in1_ar_bits_addr = 0;
    auto_in1_ar_bits_len = 0; auto_in1_r_ready = 0;
    auto_out_aw_ready = 0; auto_out_w_ready = 0; auto_out_b_valid = 0; auto_out_b_bits_id = 0;
    auto_out_b_bits_resp = 0; auto_out_ar_ready = 0; auto_out_r_valid = 0; auto_out_r_bits_id = 0;
    auto_out_r_bits_data = 0; auto_out_r_bits_resp = 0; auto_out_r_bits_last = 0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    // Reset gating: requests present while reset is low must not be forwarded or acknowledged.
    #3;
    auto_in0_aw_valid = 1; auto_in1_ar_valid = 1; auto_out_aw_ready = 1; auto_out_ar_ready = 1;
    auto_in0_w_valid = 1; auto_out_w_ready = 1;
    #1;
    chk("rst_out_aw_valid", auto_out_aw_valid, 0);
    chk("rst_in0_aw_ready", auto_in0_aw_ready, 0);
    chk("rst_out_ar_valid", auto_out_ar_valid, 0);
    chk("rst_in1_ar_ready", auto_in1_ar_ready, 0);
    chk("rst_out_w_valid", auto_out_w_valid, 0);
    chk("rst_in0_w_ready", auto_in0_w_ready, 0);
    #8;
    clear_inputs();
    reset = 1'b1;
    tick();

    // Both requesters contend with ids 3 and 5; pointer starts at in0.
    auto_out_aw_ready = 1;
    auto_in0_aw_valid = 1; auto_in0_aw_bits_id = 3; auto_in0_aw_bits_addr = 31'h100; auto_in0_aw_bits_len = 1;
    auto_in1_aw_valid = 1; auto_in1_aw_bits_id = 5; auto_in1_aw_bits_addr = 31'h200; auto_in1_aw_bits_len = 0;
    #1;
    chk("pair1_aw_valid", auto_out_aw_valid, 1);
    chk("pair1_aw_id", auto_out_aw_bits_id, 4'h3);
    chk("pair1_aw_addr", auto_out_aw_bits_addr, 31'h100);
    chk("pair1_in0_aw_ready", auto_in0_aw_ready, 1);
    chk("pair1_in1_aw_ready", auto_in1_aw_ready, 0);
    chk("pair1_idle_w_valid", auto_out_w_valid, 0);
    tick();
    // Burst from in0: two beats; in1 W is blocked and AW is suppressed.
    auto_in0_aw_valid = 0;
    auto_out_w_ready = 1;
    auto_in0_w_valid = 1; auto_in0_w_bits_data = 64'hAAAA_0001; auto_in0_w_bits_strb = 8'hFF; auto_in0_w_bits_last = 0;
    auto_in1_w_valid = 1; auto_in1_w_bits_data = 64'hBBBB_0001; auto_in1_w_bits_strb = 8'h0F; auto_in1_w_bits_last = 1;
    #1;
    chk("b0_out_aw_valid", auto_out_aw_valid, 0);
    chk("b0_in1_aw_ready", auto_in1_aw_ready, 0);
    chk("b0_out_w_valid", auto_out_w_valid, 1);
    chk("b0_out_w_data", auto_out_w_bits_data, 64'hAAAA_0001);
    chk("b0_in0_w_ready", auto_in0_w_ready, 1);
    chk("b0_in1_w_ready", auto_in1_w_ready, 0);
    tick();
    auto_in0_w_bits_data = 64'hAAAA_0002; auto_in0_w_bits_last = 1;
    #1;
    chk("b0_last", auto_out_w_bits_last, 1);
    chk("b0_last_in1_aw_ready", auto_in1_aw_ready, 0);
    tick();
    // Back in IDLE: pointer now favours in1 even with in0 contending again.
    auto_in0_w_valid = 0;
    auto_in0_aw_valid = 1;
    #1;
    chk("pair2_aw_id", auto_out_aw_bits_id, 4'hD);
    chk("pair2_in1_aw_ready", auto_in1_aw_ready, 1);
    chk("pair2_in0_aw_ready", auto_in0_aw_ready, 0);
    chk("pair2_idle_in1_w_ready", auto_in1_w_ready, 0);
    tick();
    // in1 single-beat burst; in1 keeps AW valid to form the third pair.
    #1;
    chk("b1_in1_w_ready", auto_in1_w_ready, 1);
    chk("b1_out_w_data", auto_out_w_bits_data, 64'hBBBB_0001);
    chk("b1_out_w_strb", auto_out_w_bits_strb, 8'h0F);
    chk("b1_last_in0_aw_ready", auto_in0_aw_ready, 0);
    tick();
    auto_in1_w_valid = 0;
    #1;
    chk("pair3_aw_id", auto_out_aw_bits_id, 4'h3);
    chk("pair3_in0_aw_ready", auto_in0_aw_ready, 1);
    tick();
    auto_in0_aw_valid = 0; auto_in1_aw_valid = 0;
    auto_in0_w_valid = 1; auto_in0_w_bits_last = 1;
    tick();
    auto_in0_w_valid = 0;

    // Hold: pointer is in1, in0 alone requests with slave stalled; in1 joins next cycle.
    auto_out_aw_ready = 0;
    auto_in0_aw_valid = 1; auto_in0_aw_bits_id = 6;
    #1;
    chk("hold_c1_single_grant", auto_out_aw_bits_id, 4'h6);
    chk("hold_c1_valid", auto_out_aw_valid, 1);
    tick();
    auto_in1_aw_valid = 1; auto_in1_aw_bits_id = 1; auto_in1_aw_bits_len = 3;
    for (int c = 2; c <= 5; c++) begin
      #1;
      chk($sformatf("hold_c%0d_id", c), auto_out_aw_bits_id, 4'h6);
      chk($sformatf("hold_c%0d_in1_rdy", c), auto_in1_aw_ready, 0);
      tick();
    end
    auto_out_aw_ready = 1;
    #1;
    chk("hold_fire_id", auto_out_aw_bits_id, 4'h6);
    chk("hold_fire_in0_rdy", auto_in0_aw_ready, 1);
    tick();
    auto_in0_aw_valid = 0;
    auto_in0_w_valid = 1; auto_in0_w_bits_last = 1;
    tick();

    // in1 burst of 4 beats while in0 drives W and AW throughout.
    auto_in0_w_bits_last = 0;
    auto_in0_aw_valid = 1; auto_in0_aw_bits_id = 4;
    #1;
    chk("len3_aw_id", auto_out_aw_bits_id, 4'h9);
    chk("len3_aw_len", auto_out_aw_bits_len, 8'd3);
    tick();
    auto_in1_aw_valid = 0;
    for (int b = 0; b < 4; b++) begin
      auto_in1_w_valid = 1; auto_in1_w_bits_data = 64'h1000 + 64'(b); auto_in1_w_bits_last = (b == 3);
      #1;
      chk($sformatf("len3_beat%0d_in0_w_ready", b), auto_in0_w_ready, 0);
      chk($sformatf("len3_beat%0d_in1_w_ready", b), auto_in1_w_ready, 1);
      chk($sformatf("len3_beat%0d_in0_aw_ready", b), auto_in0_aw_ready, 0);
      chk($sformatf("len3_beat%0d_data", b), auto_out_w_bits_data, 64'h1000 + 64'(b));
      tick();
    end
    auto_in1_w_valid = 0;
    #1;
    chk("len3_idle_in0_aw_ready", auto_in0_aw_ready, 1);
    chk("len3_idle_aw_id", auto_out_aw_bits_id, 4'h4);
    chk("len3_idle_w_valid", auto_out_w_valid, 0);

    // Reset in the middle of an in1 burst.
    auto_in0_aw_valid = 0; auto_in0_w_valid = 0;
    auto_in1_aw_valid = 1; auto_in1_aw_bits_id = 2;
    #1;
    chk("rb_aw_id", auto_out_aw_bits_id, 4'hA);
    tick();
    auto_in1_aw_valid = 0;
    auto_in1_w_valid = 1; auto_in1_w_bits_last = 0;
    tick();
    tick();
    auto_in0_aw_valid = 1; auto_in0_ar_valid = 1; auto_in0_ar_bits_id = 7; auto_out_ar_ready = 1;
    #1;
    chk("rb_pre_in1_w_ready", auto_in1_w_ready, 1);
    chk("rb_pre_out_ar_valid", auto_out_ar_valid, 1);
    reset = 1'b0;
    #1;
    chk("rb_in1_w_ready", auto_in1_w_ready, 0);
    chk("rb_out_w_valid", auto_out_w_valid, 0);
    chk("rb_out_aw_valid", auto_out_aw_valid, 0);
    chk("rb_in0_aw_ready", auto_in0_aw_ready, 0);
    chk("rb_out_ar_valid", auto_out_ar_valid, 0);
    chk("rb_in0_ar_ready", auto_in0_ar_ready, 0);
    tick();
    tick();
    auto_in0_aw_valid = 0; auto_in0_ar_valid = 0;
    reset = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("post_rst_c%0d_in1_w_ready", c), auto_in1_w_ready, 0);
      chk($sformatf("post_rst_c%0d_out_w_valid", c), auto_out_w_valid, 0);
      tick();
    end
    auto_in1_aw_valid = 1; auto_in1_aw_bits_id = 0;
    #1;
    chk("post_rst_aw_id", auto_out_aw_bits_id, 4'h8);
    tick();
    auto_in1_aw_valid = 0;
    #1;
    chk("post_rst_in1_w_ready", auto_in1_w_ready, 1);
    auto_in1_w_bits_last = 1;
    tick();
    auto_in1_w_valid = 0;

    // Response routing on out ID bit 3.
    auto_out_r_valid = 1; auto_out_r_bits_id = 4'hA; auto_out_r_bits_data = 64'h1234;
    auto_out_r_bits_last = 1; auto_out_r_bits_resp = 2'b10;
    auto_in1_r_ready = 1; auto_in0_r_ready = 0;
    #1;
    chk("r_in1_valid", auto_in1_r_valid, 1);
    chk("r_in1_id", auto_in1_r_bits_id, 3'd2);
    chk("r_in1_data", auto_in1_r_bits_data, 64'h1234);
    chk("r_in1_last", auto_in1_r_bits_last, 1);
    chk("r_in1_resp", auto_in1_r_bits_resp, 2'b10);
    chk("r_in0_valid", auto_in0_r_valid, 0);
    chk("r_out_ready_hi", auto_out_r_ready, 1);
    auto_in1_r_ready = 0; auto_in0_r_ready = 1;
    #1;
    chk("r_out_ready_lo", auto_out_r_ready, 0);
    auto_out_r_valid = 0;
    auto_out_b_valid = 1; auto_out_b_bits_id = 4'h5; auto_out_b_bits_resp = 2'b01;
    auto_in0_b_ready = 1; auto_in1_b_ready = 0;
    #1;
    chk("b_in0_valid", auto_in0_b_valid, 1);
    chk("b_in0_id", auto_in0_b_bits_id, 3'd5);
    chk("b_in0_resp", auto_in0_b_bits_resp, 2'b01);
    chk("b_in1_valid", auto_in1_b_valid, 0);
    chk("b_out_ready", auto_out_b_ready, 1);
    auto_out_b_valid = 0;
    tick();

    // Back-to-back AR from in0 only: one handshake every cycle.
    auto_out_ar_ready = 1; auto_in0_ar_valid = 1;
    for (int k = 0; k < 4; k++) begin
      auto_in0_ar_bits_id = 3'(k + 1); auto_in0_ar_bits_addr = 31'h4000 + 31'(k);
      #1;
      chk($sformatf("ar_b2b%0d_valid", k), auto_out_ar_valid, 1);
      chk($sformatf("ar_b2b%0d_id", k), auto_out_ar_bits_id, 4'(k + 1));
      chk($sformatf("ar_b2b%0d_addr", k), auto_out_ar_bits_addr, 31'h4000 + 31'(k));
      chk($sformatf("ar_b2b%0d_ready", k), auto_in0_ar_ready, 1);
      tick();
    end
    // Last AR handshake was in0, so contention now goes to in1.
    auto_in1_ar_valid = 1; auto_in1_ar_bits_id = 3;
    #1;
    chk("ar_contend_id", auto_out_ar_bits_id, 4'hB);
    chk("ar_contend_in0_ready", auto_in0_ar_ready, 0);
    chk("ar_contend_in1_ready", auto_in1_ar_ready, 1);
    tick();
    #1;
    chk("ar_next_id", auto_out_ar_bits_id, 4'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
